// File: rtl/particle_cell_cache.sv
// Two-bank particle store for one cell: the active bank serves reads, the shadow bank takes this cell's writebacks.
// Optional macro CELL_CACHE_FOREIGN_COUNT_EN builds a counter for writebacks addressed to other cells.
module particle_cell_cache #(
  parameter int DATA_WIDTH            = 32,
  parameter int CELL_X                = 2,
  parameter int CELL_Y                = 2,
  parameter int CELL_Z                = 2,
  parameter int CELL_ID_WIDTH         = 4,
  parameter int MAX_CELL_PARTICLE_NUM = 290,
  parameter int CELL_ADDR_WIDTH       = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_load_valid,
  input  logic [3*DATA_WIDTH-1:0]      in_load_data,
  input  logic                         in_motion_update_enable,
  input  logic                         in_rd_en,
  input  logic [CELL_ADDR_WIDTH-1:0]   in_rd_addr,
  output logic [3*DATA_WIDTH-1:0]      out_rd_data,
  input  logic                         in_wr_valid,
  input  logic [3*DATA_WIDTH-1:0]      in_wr_data,
  input  logic [3*CELL_ID_WIDTH-1:0]   in_wr_destination_cell,
  output logic [CELL_ADDR_WIDTH-1:0]   out_particle_count,
  output logic                         out_overflow,
  output logic [CELL_ADDR_WIDTH-1:0]   out_foreign_count
);

  localparam int REC_W = 3 * DATA_WIDTH;
  localparam logic [CELL_ADDR_WIDTH-1:0] MAX_CNT = CELL_ADDR_WIDTH'(MAX_CELL_PARTICLE_NUM);
  localparam logic [CELL_ADDR_WIDTH-1:0] CNT_ONE = CELL_ADDR_WIDTH'(1);
  localparam logic [3*CELL_ID_WIDTH-1:0] MY_CELL =
    {CELL_ID_WIDTH'(CELL_X), CELL_ID_WIDTH'(CELL_Y), CELL_ID_WIDTH'(CELL_Z)};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    SWAP   = 2'd2
  } state_t;

  state_t                       state_r, state_nxt_s;
  logic                         bank_sel_r;
  logic [CELL_ADDR_WIDTH-1:0]   active_cnt_r, shadow_cnt_r;
  logic                         overflow_r;
  logic [REC_W-1:0]             mem_r [0:1][0:MAX_CELL_PARTICLE_NUM];

  logic                         match_s;
  logic                         wr_en_s, wr_bank_s;
  logic [CELL_ADDR_WIDTH-1:0]   wr_addr_s;
  logic [REC_W-1:0]             wr_data_s;
  logic                         load_acc_s, wb_acc_s, drop_s, enter_upd_s;

  logic                         rd_vld_r, rd_bank_r;
  logic [CELL_ADDR_WIDTH-1:0]   rd_addr_r, rd_cnt_r;
  logic [REC_W-1:0]             rd_data_r;

  assign match_s = (in_wr_destination_cell == MY_CELL);

  // Next-state and single write-port control; slot 0 of each bank stays unused.
  always_comb begin
    state_nxt_s = state_r;
    wr_en_s     = 1'b0;
    wr_bank_s   = bank_sel_r;
    wr_addr_s   = active_cnt_r + CNT_ONE;
    wr_data_s   = in_load_data;
    load_acc_s  = 1'b0;
    wb_acc_s    = 1'b0;
    drop_s      = 1'b0;
    enter_upd_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_motion_update_enable) begin
          state_nxt_s = UPDATE;
          enter_upd_s = 1'b1;
        end else if (in_load_valid) begin
          if (active_cnt_r < MAX_CNT) begin
            wr_en_s    = 1'b1;
            load_acc_s = 1'b1;
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      UPDATE: begin
        if (!in_motion_update_enable) begin
          state_nxt_s = SWAP;
        end else begin
          state_nxt_s = UPDATE;
        end
        wr_bank_s = ~bank_sel_r;
        wr_addr_s = shadow_cnt_r + CNT_ONE;
        wr_data_s = in_wr_data;
        if (in_wr_valid && match_s) begin
          if (shadow_cnt_r < MAX_CNT) begin
            wr_en_s  = 1'b1;
            wb_acc_s = 1'b1;
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      SWAP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM, bank select, counts and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      bank_sel_r   <= 1'b0;
      active_cnt_r <= '0;
      shadow_cnt_r <= '0;
      overflow_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == SWAP) begin
        bank_sel_r   <= ~bank_sel_r;
        active_cnt_r <= shadow_cnt_r;
      end else if (load_acc_s) begin
        active_cnt_r <= active_cnt_r + CNT_ONE;
      end
      if (enter_upd_s) begin
        shadow_cnt_r <= '0;
      end else if (wb_acc_s) begin
        shadow_cnt_r <= shadow_cnt_r + CNT_ONE;
      end
      if (enter_upd_s) begin
        overflow_r <= 1'b0;
      end else if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Particle storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem_r[wr_bank_s][wr_addr_s] <= wr_data_s;
    end
  end

  // Two-stage read: bank and count are captured at issue so a SWAP-cycle read sees the old bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_r  <= 1'b0;
      rd_bank_r <= 1'b0;
      rd_addr_r <= '0;
      rd_cnt_r  <= '0;
      rd_data_r <= '0;
    end else begin
      rd_vld_r  <= in_rd_en;
      rd_bank_r <= bank_sel_r;
      rd_addr_r <= in_rd_addr;
      rd_cnt_r  <= active_cnt_r;
      if (!rd_vld_r) begin
        rd_data_r <= '0;
      end else if (rd_addr_r == '0) begin
        rd_data_r <= REC_W'(rd_cnt_r);
      end else if (rd_addr_r > rd_cnt_r) begin
        rd_data_r <= '0;
      end else begin
        rd_data_r <= mem_r[rd_bank_r][rd_addr_r];
      end
    end
  end

  assign out_rd_data        = rd_data_r;
  assign out_particle_count = active_cnt_r;
  assign out_overflow       = overflow_r;

`ifdef CELL_CACHE_FOREIGN_COUNT_EN
  logic [CELL_ADDR_WIDTH-1:0] foreign_r;
  logic                       foreign_hit_s;

  assign foreign_hit_s = (state_r == UPDATE) && in_wr_valid && !match_s;

  // Saturating count of writebacks bound for other cells during one update.
  always_ff @(posedge clk) begin
    if (rst) begin
      foreign_r <= '0;
    end else if (enter_upd_s) begin
      foreign_r <= '0;
    end else if (foreign_hit_s && (foreign_r != '1)) begin
      foreign_r <= foreign_r + CNT_ONE;
    end else begin
      foreign_r <= foreign_r;
    end
  end

  assign out_foreign_count = foreign_r;
`else
  assign out_foreign_count = '0;
`endif

endmodule
